// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the RAM data-port arbiter: requester identity and helpers.
package ram_port_arbiter_pkg;

  // m0 = BIOS loader, m1 = core load/store unit
  typedef enum logic {
    OWNER_BIOS = 1'b0,
    OWNER_CORE = 1'b1
  } ram_owner_e;

  // The requester that is not the given one
  function automatic ram_owner_e other_owner(input ram_owner_e owner);
    return (owner == OWNER_BIOS) ? OWNER_CORE : OWNER_BIOS;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rsp_tracker.sv
// Read-response tag pipeline: carries {valid, owner} for READ_LATENCY
// qualified cycles and raises the matching per-owner rvalid at the tail.
module ram_port_arbiter_rsp_tracker
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       i_push,
  input  ram_owner_e i_owner,
  output logic       o_bios_rvalid,
  output logic       o_core_rvalid
);

  logic [READ_LATENCY-1:0] vld_q;
  logic [READ_LATENCY-1:0] vld_d;
  logic [READ_LATENCY-1:0] own_q;
  logic [READ_LATENCY-1:0] own_d;

  // Shift one stage per qualified cycle, inserting the current read tag at stage 0
  always_comb begin
    vld_d = vld_q;
    own_d = own_q;
    if (clk_en) begin
      vld_d[0] = i_push;
      own_d[0] = i_owner;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        own_d[i] = own_q[i-1];
      end
    end
  end

  // Pipeline registers; reset discards every in-flight response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
    end
  end

  // Decode the tail tag into per-owner valids
  always_comb begin
    o_bios_rvalid = vld_q[READ_LATENCY-1] &&
                    (ram_owner_e'(own_q[READ_LATENCY-1]) == OWNER_BIOS);
    o_core_rvalid = vld_q[READ_LATENCY-1] &&
                    (ram_owner_e'(own_q[READ_LATENCY-1]) == OWNER_CORE);
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbiter sharing the RAM data port between the BIOS loader (m0) and the
// core LSU (m1): boot gating, round-robin with bounded hold, tagged read return.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_HOLD     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic                i_booted,
  input  logic                i_m0_req,
  input  logic                i_m0_we,
  input  logic [DATA_W/8-1:0] i_m0_be,
  input  logic [ADDR_W-1:0]   i_m0_addr,
  input  logic [DATA_W-1:0]   i_m0_wdata,
  input  logic                i_m1_req,
  input  logic                i_m1_we,
  input  logic [DATA_W/8-1:0] i_m1_be,
  input  logic [ADDR_W-1:0]   i_m1_addr,
  input  logic [DATA_W-1:0]   i_m1_wdata,
  output logic                o_m0_gnt,
  output logic                o_m1_gnt,
  output logic                o_m0_rvalid,
  output logic                o_m1_rvalid,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_read_req,
  output logic [ADDR_W-1:0]   o_read_addr,
  input  logic [DATA_W-1:0]   i_read_data,
  output logic                o_write_enable,
  output logic [DATA_W/8-1:0] o_byte_enable,
  output logic [ADDR_W-1:0]   o_write_addr,
  output logic [DATA_W-1:0]   o_write_data
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD - 1);

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_cmd_t;

  ram_owner_e        last_owner_q, last_owner_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              active_q, active_d;

  logic       m0_elig, m1_elig;
  logic       any_gnt;
  ram_owner_e gnt_owner;
  ram_cmd_t   m0_cmd, m1_cmd, sel_cmd;
  logic       rd_push;
  logic       bios_rvalid, core_rvalid;

  // Arbitration. The owner may keep the port only if it held it on the previous
  // qualified cycle; after reset or an idle cycle, contention goes to the
  // requester that is not last_owner, so the first contention goes to m1.
  always_comb begin
    m0_elig   = i_m0_req;
    m1_elig   = i_m1_req && i_booted;
    any_gnt   = 1'b0;
    gnt_owner = OWNER_BIOS;
    if (m0_elig && m1_elig) begin
      any_gnt   = 1'b1;
      gnt_owner = (active_q && (hold_cnt_q < HOLD_SAT)) ? last_owner_q
                                                        : other_owner(last_owner_q);
    end else if (m0_elig) begin
      any_gnt   = 1'b1;
      gnt_owner = OWNER_BIOS;
    end else if (m1_elig) begin
      any_gnt   = 1'b1;
      gnt_owner = OWNER_CORE;
    end
    if (!rst) begin
      any_gnt = 1'b0;
    end
  end

  // Hold counter and ownership update on qualified edges
  always_comb begin
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    active_d     = active_q;
    if (clk_en) begin
      if (!any_gnt) begin
        hold_cnt_d = '0;
        active_d   = 1'b0;
      end else if (gnt_owner == last_owner_q) begin
        hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + 1'b1;
        active_d   = 1'b1;
      end else begin
        last_owner_d = gnt_owner;
        hold_cnt_d   = '0;
        active_d     = 1'b1;
      end
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner_q <= OWNER_BIOS;
      hold_cnt_q   <= '0;
      active_q     <= 1'b0;
    end else begin
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      active_q     <= active_d;
    end
  end

  // Command selection and RAM-side outputs, all zero without a grant or in reset
  always_comb begin
    m0_cmd  = '{we: i_m0_we, be: i_m0_be, addr: i_m0_addr, wdata: i_m0_wdata};
    m1_cmd  = '{we: i_m1_we, be: i_m1_be, addr: i_m1_addr, wdata: i_m1_wdata};
    sel_cmd = (gnt_owner == OWNER_BIOS) ? m0_cmd : m1_cmd;

    o_m0_gnt       = any_gnt && (gnt_owner == OWNER_BIOS);
    o_m1_gnt       = any_gnt && (gnt_owner == OWNER_CORE);
    o_read_req     = 1'b0;
    o_read_addr    = '0;
    o_write_enable = 1'b0;
    o_byte_enable  = '0;
    o_write_addr   = '0;
    o_write_data   = '0;
    if (any_gnt) begin
      if (sel_cmd.we) begin
        o_write_enable = 1'b1;
        o_byte_enable  = sel_cmd.be;
        o_write_addr   = sel_cmd.addr;
        o_write_data   = sel_cmd.wdata;
      end else begin
        o_read_req  = 1'b1;
        o_read_addr = sel_cmd.addr;
      end
    end
    rd_push     = any_gnt && !sel_cmd.we;
    o_rdata     = rst ? i_read_data : '0;
    o_m0_rvalid = rst && bios_rvalid;
    o_m1_rvalid = rst && core_rvalid;
  end

  ram_port_arbiter_rsp_tracker #(
    .READ_LATENCY (READ_LATENCY)
  ) u_rsp_tracker (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .i_push        (rd_push),
    .i_owner       (gnt_owner),
    .o_bios_rvalid (bios_rvalid),
    .o_core_rvalid (core_rvalid)
  );

endmodule
